frame_sink: RTL and testbench
=============================

# frame_sink

Collects the valid-qualified 8-bit pixel stream produced by the convolution stage into an on-chip frame buffer in raster order. It flags completion and a running checksum, then replays the stored frame on a ready/valid output port for the downstream consumer or the bench to drain. It sits at the output end of the conv pipeline and is the receiving counterpart of the pixel streamer that feeds `pxl_in`.

## Interface

**Parameters**
- `W`, default 218: frame width in pixels (valid output width of a 3x3 conv on 220 columns).
- `H`, default 218: frame height in rows.
- `DW`, default 8: pixel width.
- `AW`, default 16: buffer address width; must satisfy 2^AW ≥ W*H.

**Ports**
- `clk`, in, 1: single clock; everything is on posedge.
- `reset`, in, 1: synchronous, active-low reset.
- `pxl_in`, in, DW: pixel from the conv stage.
- `valid`, in, 1: `pxl_in` is a real output pixel this cycle.
- `drain_start`, in, 1: single-cycle request to begin replay; honoured only in FULL.
- `frame_done`, out, 1: high while in FULL.
- `checksum`, out, 16: modulo-2^16 sum of accepted pixels of the current frame.
- `overflow`, out, 1: sticky; a `valid` pixel arrived outside COLLECT.
- `pxl_out`, out, DW: replayed pixel.
- `out_valid`, out, 1: `pxl_out` holds a pixel.
- `out_ready`, in, 1: consumer accepts when `out_valid` and `out_ready` are both high.
- `col`, out, 16: current write column, for debug.
- `row`, out, 16: current write row, for debug.

## Operation

- Reset (`reset`==0 at a posedge) puts the block in state COLLECT.
  - Outputs after reset: `frame_done`=0, `checksum`=0, `overflow`=0, `out_valid`=0, `pxl_out`=0, `col`=0, `row`=0.
  - Buffer contents are not cleared.
- **COLLECT**
  - Each cycle with `valid`=1:
    - write `pxl_in` at address `row*W+col`;
    - add `pxl_in` (zero-extended) to `checksum`;
    - increment `col`.
  - When `col`==W-1: `col` goes to 0 and `row` increments.
  - When the accepted pixel is at `row`==H-1 and `col`==W-1: go to FULL; `col` and `row` clear.
  - `valid`=0 cycles are ignored, so gaps in the stream are legal.
- **FULL**
  - `frame_done`=1.
  - Incoming `valid` pixels are dropped and set `overflow`.
  - `drain_start`=1 moves to DRAIN and resets the read address to 0.
- **DRAIN**
  - Replays addresses 0 to W*H-1 in order, one pixel per accepted handshake.
  - After the handshake on the last pixel: go to COLLECT, clear `checksum`, clear `frame_done`.
  - `valid` pixels arriving in DRAIN are dropped and set `overflow`.
- **Checksum** wraps modulo 2^16. It holds its value through FULL and DRAIN and clears only on DRAIN→COLLECT or reset.
- **Overflow** stays set until reset.
- **Reset mid-frame or mid-drain** aborts immediately; the partial frame is discarded.

## Timing

- Write path: a pixel presented with `valid` at edge N is in the buffer at edge N+1. `checksum` and `col`/`row` update at edge N+1.
- `frame_done` rises the cycle after the last pixel's edge.
- `drain_start` sampled at edge D: `out_valid` rises at edge D+2, holding `pxl_out`=buffer[0]. This includes one cycle of synchronous RAM read latency.
- With `out_ready` held at 1, one pixel transfers per cycle, with no bubbles after the first.
- While `out_valid`=1 and `out_ready`=0, `pxl_out` and `out_valid` must stay stable.
- `out_valid` may not depend combinationally on `out_ready`; `out_ready` may toggle every cycle.
- `out_valid` drops at the edge following the last handshake; the state is COLLECT on that same edge.
- Pixels presented on that same edge are accepted into the new frame.

## Structure

- Shared package `frame_pkg`:
  - state enum COLLECT/FULL/DRAIN;
  - default frame dimensions 218x218;
  - checksum width constant.
- Sub-module `frame_ram`: single-clock simple dual-port RAM, depth 2^AW × DW, with a synchronous read and a read-enable. It is used with its read-enable tied to "advance" so `frame_sink` can hold the output under stall.
- The output stage is a one-entry skid/hold register in `frame_sink`.

## Test plan

1. **Reset values:** hold `reset`=0 for 3 cycles, then release → all outputs 0 and state COLLECT.
2. **Small full frame** (W=4, H=3): stream pixels 1..12 with `valid`=1 continuously → `frame_done`=1 one cycle after pixel 12, `checksum`=78. Then pulse `drain_start` with `out_ready`=1 → `pxl_out` 1..12 on 12 consecutive cycles starting at D+2, then `out_valid`=0.
3. **Gapped input** (W=4, H=3): pixels 0xFF×12 with `valid` alternating 1/0 → `frame_done` after 23 cycles, `checksum`=0x0BF4, and `col`/`row` advance only on valid cycles.
4. **Backpressure** (W=4, H=3): during drain, `out_ready` pattern 1,0,0,1,0,1,… → each pixel held stable while not ready, none lost or duplicated, 12 handshakes total.
5. **Overflow:** `valid`=1 while in FULL, and again while in DRAIN → `overflow`=1 and stays 1. Buffer contents and `checksum` are unchanged; the drained data equals the original frame.
6. **Reset mid-drain:** pull `reset` low after 5 handshakes → `out_valid`=0, state COLLECT. A new 12-pixel frame streamed afterward drains correctly from address 0.

Source files
------------

// File: rtl/frame_pkg.sv
// rtl/frame_pkg.sv - shared types and constants for the frame sink
package frame_pkg;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        FULL    = 2'd1,
        DRAIN   = 2'd2
    } frame_state_t;

    // 3x3 conv on 220 columns leaves 218 valid outputs per axis
    localparam int FRAME_W = 218;
    localparam int FRAME_H = 218;
    localparam int CSUM_W  = 16;

endpackage

// File: rtl/frame_ram.sv
// rtl/frame_ram.sv - simple dual-port frame buffer with synchronous read
//
// Ports:
//   clk            single clock
//   we/waddr/wdata write port
//   re/raddr       read port; rdata updates only on edges with re=1
//   rdata          registered read data, holds while re=0
module frame_ram #(
    parameter int AW = 16,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/frame_sink.sv
// rtl/frame_sink.sv - collects a raster pixel frame, then replays it on a ready/valid port
//
// Ports:
//   clk, reset            clock; synchronous active-low reset
//   pxl_in, valid         incoming conv pixels
//   drain_start           replay request, honoured only in FULL
//   frame_done            high while a complete frame waits in FULL
//   checksum              mod-2^16 sum of the accepted pixels of this frame
//   overflow              sticky: a valid pixel arrived outside COLLECT
//   pxl_out, out_valid,   replay stream
//   out_ready
//   col, row              current write position
module frame_sink
    import frame_pkg::*;
#(
    parameter int W  = FRAME_W,
    parameter int H  = FRAME_H,
    parameter int DW = 8,
    parameter int AW = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DW-1:0]     pxl_in,
    input  logic              valid,
    input  logic              drain_start,
    output logic              frame_done,
    output logic [CSUM_W-1:0] checksum,
    output logic              overflow,
    output logic [DW-1:0]     pxl_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       col,
    output logic [15:0]       row
);

    localparam logic [AW:0] TOTAL    = (AW+1)'(W * H);
    localparam logic [15:0] COL_LAST = 16'(W - 1);
    localparam logic [15:0] ROW_LAST = 16'(H - 1);

    frame_state_t  state;
    frame_state_t  state_nxt;
    logic [AW-1:0] waddr;
    // one bit wider than the address so W*H == 2^AW still terminates
    logic [AW:0]   rd_cnt;
    logic          rd_valid;
    logic [DW-1:0] ram_rdata;
    logic          wr_en;
    logic          last_pix;
    logic          advance;
    logic          rd_issue;
    logic          last_hs;

    assign wr_en    = (state == COLLECT) && valid;
    assign last_pix = (row == ROW_LAST) && (col == COL_LAST);
    // the output register can take a new value: empty or being consumed
    assign advance  = !out_valid || out_ready;
    assign rd_issue = (state == DRAIN) && advance && (rd_cnt != TOTAL);
    // final pixel leaving: all reads issued and nothing left in the RAM stage
    assign last_hs  = (state == DRAIN) && out_valid && out_ready
                      && !rd_valid && (rd_cnt == TOTAL);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= COLLECT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            COLLECT: if (wr_en && last_pix) state_nxt = FULL;
            FULL:    if (drain_start)       state_nxt = DRAIN;
            DRAIN:   if (last_hs)           state_nxt = COLLECT;
            default:                        state_nxt = COLLECT;
        endcase
    end

    always_comb begin
        frame_done = (state == FULL);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            col      <= '0;
            row      <= '0;
            waddr    <= '0;
            checksum <= '0;
            overflow <= 1'b0;
        end else begin
            if (valid && (state != COLLECT)) begin
                overflow <= 1'b1;
            end
            if (wr_en) begin
                checksum <= checksum + CSUM_W'(pxl_in);
                if (last_pix) begin
                    col   <= '0;
                    row   <= '0;
                    waddr <= '0;
                end else if (col == COL_LAST) begin
                    col   <= '0;
                    row   <= row + 16'd1;
                    waddr <= waddr + AW'(1);
                end else begin
                    col   <= col + 16'd1;
                    waddr <= waddr + AW'(1);
                end
            end
            if (last_hs) begin
                checksum <= '0;
            end
        end
    end

    // Two-stage replay pipeline: RAM read register, then the output hold
    // register. Both stages move only on advance, so a stall freezes them
    // together and nothing is lost or duplicated.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_cnt    <= '0;
            rd_valid  <= 1'b0;
            out_valid <= 1'b0;
            pxl_out   <= '0;
        end else if (state != DRAIN) begin
            rd_cnt    <= '0;
            rd_valid  <= 1'b0;
            out_valid <= 1'b0;
        end else if (advance) begin
            out_valid <= rd_valid;
            if (rd_valid) begin
                pxl_out <= ram_rdata;
            end
            rd_valid <= rd_issue;
            if (rd_issue) begin
                rd_cnt <= rd_cnt + (AW+1)'(1);
            end
        end
    end

    frame_ram #(
        .AW (AW),
        .DW (DW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (waddr),
        .wdata (pxl_in),
        .re    (rd_issue),
        .raddr (rd_cnt[AW-1:0]),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_frame_sink.sv
// tb/tb_frame_sink.sv - directed self-checking bench for frame_sink on a 4x3 frame
module tb_frame_sink;

    logic        clk;
    logic        reset;
    logic [7:0]  pxl_in;
    logic        valid;
    logic        drain_start;
    logic        frame_done;
    logic [15:0] checksum;
    logic        overflow;
    logic [7:0]  pxl_out;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] col;
    logic [15:0] row;

    int checks = 0;
    int errors = 0;
    int n;
    logic [7:0] got [16];
    logic [5:0] pat;

    frame_sink #(
        .W  (4),
        .H  (3),
        .DW (8),
        .AW (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pxl_in      (pxl_in),
        .valid       (valid),
        .drain_start (drain_start),
        .frame_done  (frame_done),
        .checksum    (checksum),
        .overflow    (overflow),
        .pxl_out     (pxl_out),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .col         (col),
        .row         (row)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic stream(input logic [7:0] base);
        for (int i = 0; i < 12; i++) begin
            valid  = 1'b1;
            pxl_in = base + 8'(i);
            tick();
        end
        valid = 1'b0;
    endtask

    // Replays with optional backpressure pattern and an optional stray
    // valid pixel; stops after max_hs handshakes or a cycle budget.
    task automatic drain(input bit bp, input bit inject, input int max_hs, output int cnt);
        logic [7:0] held;
        logic       stall;
        cnt   = 0;
        stall = 1'b0;
        held  = '0;
        drain_start = 1'b1;
        tick();
        drain_start = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (stall) begin
                chk("hold_pxl", pxl_out, held);
                chk("hold_valid", out_valid, 1);
            end
            out_ready = bp ? pat[cyc % 6] : 1'b1;
            valid     = inject && (cyc == 3);
            pxl_in    = 8'h77;
            if (out_valid && out_ready) begin
                if (cnt < 16) got[cnt] = pxl_out;
                cnt++;
            end
            stall = out_valid && !out_ready;
            held  = pxl_out;
            tick();
            if (cnt >= max_hs) break;
        end
        valid     = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        pat         = 6'b101001;
        reset       = 1'b0;
        pxl_in      = '0;
        valid       = 1'b0;
        drain_start = 1'b0;
        out_ready   = 1'b0;

        // 1: reset values
        tick(); tick(); tick();
        reset = 1'b1;
        chk("rst_frame_done", frame_done, 0);
        chk("rst_checksum", checksum, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_pxl_out", pxl_out, 0);
        chk("rst_col", col, 0);
        chk("rst_row", row, 0);

        // 2: continuous frame 1..12
        for (int i = 1; i <= 12; i++) begin
            valid  = 1'b1;
            pxl_in = 8'(i);
            tick();
            if (i == 5) begin
                chk("t2_col5", col, 1);
                chk("t2_row5", row, 1);
            end
            if (i == 11) chk("t2_done_early", frame_done, 0);
        end
        valid = 1'b0;
        chk("t2_frame_done", frame_done, 1);
        chk("t2_checksum", checksum, 78);
        chk("t2_col_clr", col, 0);
        chk("t2_row_clr", row, 0);

        // 5a: stray pixel while FULL
        valid  = 1'b1;
        pxl_in = 8'h99;
        tick();
        valid = 1'b0;
        chk("t5_ovf_full", overflow, 1);
        chk("t5_csum_full", checksum, 78);
        chk("t5_done_full", frame_done, 1);

        // 2: drain timing, first pixel at D+2, no bubbles
        out_ready   = 1'b1;
        drain_start = 1'b1;
        tick();
        drain_start = 1'b0;
        chk("t2_ov_d0", out_valid, 0);
        tick();
        chk("t2_ov_d1", out_valid, 0);
        tick();
        for (int k = 1; k <= 12; k++) begin
            chk("t2_ov", out_valid, 1);
            chk("t2_pxl", pxl_out, k);
            tick();
        end
        chk("t2_ov_end", out_valid, 0);
        chk("t2_done_end", frame_done, 0);
        chk("t2_csum_end", checksum, 0);
        chk("t2_ovf_sticky", overflow, 1);

        // 3: gapped 0xFF frame
        for (int i = 0; i < 23; i++) begin
            valid  = (i % 2 == 0);
            pxl_in = 8'hFF;
            tick();
            if (i == 0) chk("t3_col_v", col, 1);
            if (i == 1) chk("t3_col_gap", col, 1);
            if (i == 8) begin
                chk("t3_col8", col, 1);
                chk("t3_row8", row, 1);
            end
            if (i == 21) chk("t3_done_early", frame_done, 0);
        end
        valid = 1'b0;
        chk("t3_frame_done", frame_done, 1);
        chk("t3_checksum", checksum, 16'h0BF4);
        drain(1'b0, 1'b0, 12, n);
        chk("t3_hs", n, 12);
        chk("t3_ov_end", out_valid, 0);
        for (int i = 0; i < 12; i++) chk("t3_data", got[i], 8'hFF);

        // 4: backpressure 1,0,0,1,0,1...
        stream(8'h20);
        chk("t4_checksum", checksum, 16'h01C2);
        chk("t4_frame_done", frame_done, 1);
        drain(1'b1, 1'b0, 12, n);
        chk("t4_hs", n, 12);
        chk("t4_ov_end", out_valid, 0);
        for (int i = 0; i < 12; i++) chk("t4_data", got[i], 8'h20 + 8'(i));

        // 6: reset after 5 handshakes
        stream(8'h40);
        drain(1'b0, 1'b0, 5, n);
        chk("t6_hs", n, 5);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("t6_ov", out_valid, 0);
        chk("t6_done", frame_done, 0);
        chk("t6_csum", checksum, 0);
        chk("t6_ovf", overflow, 0);
        chk("t6_col", col, 0);
        chk("t6_row", row, 0);
        chk("t6_pxl", pxl_out, 0);

        // 5b + 6: new frame, stray pixel while DRAIN, backpressured drain
        stream(8'h60);
        chk("t6_checksum", checksum, 16'h04C2);
        chk("t6_frame_done", frame_done, 1);
        drain(1'b1, 1'b1, 12, n);
        chk("t6_hs_full", n, 12);
        chk("t5_ovf_drain", overflow, 1);
        chk("t6_ov_end", out_valid, 0);
        chk("t6_csum_end", checksum, 0);
        for (int i = 0; i < 12; i++) chk("t6_data", got[i], 8'h60 + 8'(i));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
